// File: rtl/ddr_phy_training_pkg.sv
// ============================================================================
// Module : ddr_phy_training_pkg
// Brief  : Shared DDR PHY training states, default constants and helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ddr_phy_training_pkg;

    localparam int DEF_TAP_W         = 8;
    localparam int DEF_MAX_TAPS      = 127;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_NUM_SAMPLES   = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_CLEAR  = 4'd2,
        ST_SETTLE = 4'd3,
        ST_SAMPLE = 4'd4,
        ST_EVAL   = 4'd5,
        ST_MOVE   = 4'd6,
        ST_PASS   = 4'd7,
        ST_FAIL   = 4'd8
    } train_state_t;

    // Width able to hold the larger of two wait lengths, with a spare bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/training_wait_cnt.sv
// ============================================================================
// Module : training_wait_cnt
// Brief  : Loadable down-counter with terminal-count flag for wait phases.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module training_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/dqsw_training_ctrl.sv
// ============================================================================
// Module : dqsw_training_ctrl
// Brief  : DQS write-leveling sweep: steps the delay line until a 0->1 edge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dqsw_training_ctrl
    import ddr_phy_training_pkg::*;
#(
    parameter int TAP_W         = DEF_TAP_W,
    parameter int MAX_TAPS      = DEF_MAX_TAPS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int NUM_SAMPLES   = DEF_NUM_SAMPLES
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [1:0]       RX_DATA,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic [TAP_W-1:0] TAP_COUNT
);

    localparam int               CNT_W     = cnt_width(SETTLE_CYCLES, NUM_SAMPLES);
    localparam logic [TAP_W-1:0] c_max_tap = TAP_W'(MAX_TAPS);

    train_state_t     r_state;
    logic [TAP_W-1:0] r_tap;
    logic             r_seen_low;
    logic             r_all_hi;
    logic             r_all_lo;

    logic             r_load;
    logic             r_move;
    logic             r_dir;
    logic             r_clr;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [TAP_W-1:0] r_tap_out;

    logic             w_wait_load;
    logic [CNT_W-1:0] w_wait_val;
    logic             w_wait_en;
    logic             w_wait_tc;
    logic             w_rx_hi;
    logic             w_rx_lo;

    // One counter times both SETTLE and SAMPLE; reloaded on entry to each.
    assign w_wait_load = (r_state == ST_CLEAR) || ((r_state == ST_SETTLE) && w_wait_tc);
    assign w_wait_val  = (r_state == ST_CLEAR) ? CNT_W'(SETTLE_CYCLES - 1)
                                               : CNT_W'(NUM_SAMPLES - 1);
    assign w_wait_en   = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign w_rx_hi     = (RX_DATA == 2'b11);
    assign w_rx_lo     = (RX_DATA == 2'b00);

    training_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk        (FAB_CLK),
        .rst_n      (RESET_N),
        .i_load     (w_wait_load),
        .i_load_val (w_wait_val),
        .i_en       (w_wait_en),
        .o_tc       (w_wait_tc)
    );

    always_ff @(posedge FAB_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_tap      <= '0;
            r_seen_low <= 1'b0;
            r_all_hi   <= 1'b0;
            r_all_lo   <= 1'b0;
            r_load     <= 1'b0;
            r_move     <= 1'b0;
            r_dir      <= 1'b0;
            r_clr      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tap_out  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (START) begin
                        r_tap      <= '0;
                        r_seen_low <= 1'b0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD:   r_state <= ST_CLEAR;
                ST_CLEAR:  r_state <= ST_SETTLE;
                ST_SETTLE: begin
                    if (w_wait_tc) begin
                        r_all_hi <= 1'b1;
                        r_all_lo <= 1'b1;
                        r_state  <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_all_hi <= r_all_hi & w_rx_hi;
                    r_all_lo <= r_all_lo & w_rx_lo;
                    if (w_wait_tc) begin
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        r_state <= ST_FAIL;
                    end else if (r_all_hi && r_seen_low) begin
                        r_state <= ST_PASS;
                    end else begin
                        // A low tap arms the edge search but never ends the sweep.
                        if (r_all_lo) begin
                            r_seen_low <= 1'b1;
                        end
                        r_state <= (r_tap == c_max_tap) ? ST_FAIL : ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (r_tap != '1) begin
                        r_tap <= r_tap + 1'b1;
                    end
                    r_state <= ST_CLEAR;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Outputs are a registered decode of the current state.
            r_dir     <= 1'b1;
            r_load    <= (r_state == ST_LOAD);
            r_clr     <= (r_state == ST_CLEAR);
            r_move    <= (r_state == ST_MOVE);
            r_busy    <= (r_state != ST_IDLE) && (r_state != ST_PASS) && (r_state != ST_FAIL);
            r_done    <= (r_state == ST_PASS);
            r_err     <= (r_state == ST_FAIL);
            r_tap_out <= r_tap;
        end
    end

    assign DELAY_LINE_LOAD         = r_load;
    assign DELAY_LINE_MOVE         = r_move;
    assign DELAY_LINE_DIRECTION    = r_dir;
    assign EYE_MONITOR_CLEAR_FLAGS = r_clr;
    assign BUSY                    = r_busy;
    assign DONE                    = r_done;
    assign ERROR                   = r_err;
    assign TAP_COUNT               = r_tap_out;

endmodule

`default_nettype wire

// File: doc/dqsw_training_ctrl.md
DQSW_TRAINING_CTRL -- requirements
Module: dqsw_training_ctrl

Interface
REQ-001 SHALL have parameter TAP_W, default 8, width of the tap counter.
REQ-002 SHALL have parameter MAX_TAPS, default 127, last tap index tried before failing.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, wait after each flag clear.
REQ-004 SHALL have parameter NUM_SAMPLES, default 4, RX_DATA samples taken per tap.
REQ-005 SHALL have port FAB_CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port START, input, 1 bit: training request.
REQ-008 SHALL have port RX_DATA, input, 2 bits: captured DQ feedback from the lane IOD.
REQ-009 SHALL have port DELAY_LINE_OUT_OF_RANGE, input, 1 bit: IOD delay-line limit flag.
REQ-010 SHALL have port DELAY_LINE_LOAD, output, 1 bit: reload the delay line to its static value.
REQ-011 SHALL have port DELAY_LINE_MOVE, output, 1 bit: step the delay line one tap.
REQ-012 SHALL have port DELAY_LINE_DIRECTION, output, 1 bit: step direction, 1 = increment.
REQ-013 SHALL have port EYE_MONITOR_CLEAR_FLAGS, output, 1 bit: clear IOD eye-monitor flags.
REQ-014 SHALL have port BUSY, output, 1 bit: training in progress.
REQ-015 SHALL have port DONE, output, 1 bit: transition found.
REQ-016 SHALL have port ERROR, output, 1 bit: training failed.
REQ-017 SHALL have port TAP_COUNT, output, TAP_W bits: current or final tap index.

Function
REQ-018 SHALL implement states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, MOVE, PASS and FAIL.
REQ-019 SHALL sample START only in IDLE, PASS or FAIL; START is ignored while BUSY.
REQ-020 On START SHALL clear DONE, ERROR, TAP_COUNT and the seen_low flag, then enter LOAD.
REQ-021 LOAD SHALL last 1 cycle with DELAY_LINE_LOAD=1, then enter CLEAR.
REQ-022 CLEAR SHALL last 1 cycle with EYE_MONITOR_CLEAR_FLAGS=1, then enter SETTLE.
REQ-023 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-024 SAMPLE SHALL last NUM_SAMPLES cycles and record whether all samples are 2'b11 (all_hi) and whether all are 2'b00 (all_lo).
REQ-025 EVAL SHALL last 1 cycle and apply these checks in priority order:
- DELAY_LINE_OUT_OF_RANGE=1 -> FAIL.
- all_hi and seen_low -> PASS.
- all_lo -> set seen_low.
- TAP_COUNT==MAX_TAPS -> FAIL.
- otherwise -> MOVE.
REQ-026 Mixed samples (neither all_hi nor all_lo) SHALL neither set nor clear seen_low.
REQ-027 all_hi before any all_lo tap SHALL NOT pass; the sweep continues.
REQ-028 MOVE SHALL last 1 cycle with DELAY_LINE_MOVE=1 and DELAY_LINE_DIRECTION=1, increment TAP_COUNT by 1 without wrapping, then enter CLEAR.
REQ-029 BUSY SHALL be 1 in every state except IDLE, PASS and FAIL.
REQ-030 PASS SHALL hold DONE=1; FAIL SHALL hold ERROR=1; both SHALL hold until the next START.
REQ-031 TAP_COUNT SHALL hold its final value in PASS and FAIL.
REQ-032 DONE and ERROR SHALL never both be 1.
REQ-033 DELAY_LINE_DIRECTION SHALL be 1 at all times after reset, and SHALL be 0 during reset.
REQ-034 All outputs SHALL be registered.
REQ-035 The pulse outputs SHALL be single-cycle.

Reset
REQ-036 RESET_N=0 SHALL asynchronously force IDLE and drive every output and internal counter to 0, including during an active sweep.
REQ-037 After RESET_N deasserts, the block SHALL wait for a new START.

Structure
REQ-038 The state enumeration and default parameter constants SHALL live in the shared DDR PHY training package.
REQ-039 The SETTLE/SAMPLE cycle counter SHALL be one sub-module, training_wait_cnt, with load value, enable and terminal-count output.

Verification
REQ-040 With default parameters, RX_DATA=00 for taps 0-4 and 11 from tap 5, START SHALL produce:
- 1 LOAD pulse and 6 CLEAR pulses;
- 5 MOVE pulses;
- DONE=1 with TAP_COUNT=5, 91 cycles after START is sampled.
REQ-041 With RX_DATA stuck at 11, the sweep SHALL produce ERROR=1 with TAP_COUNT=127 and 127 MOVE pulses.
REQ-042 With DELAY_LINE_OUT_OF_RANGE asserted at tap 3, the sweep SHALL produce ERROR=1 with TAP_COUNT=3 and no further MOVE pulses.
REQ-043 Alternating 01/10 samples at taps 0-2, then 00, then 11, SHALL produce DONE with TAP_COUNT=4.
REQ-044 Applying RESET_N=0 during SETTLE SHALL drive all outputs to 0 that cycle; re-issuing START after reset SHALL restart from LOAD with TAP_COUNT=0.
REQ-045 A START pulse issued while BUSY SHALL be ignored, and the sweep result SHALL be identical to the uninterrupted run.
